// File: rtl/labft_seq_if.sv
// Job and checker-control signals of the LABFT tile sequencer.
// master: host/DMA plus checker side; slave: the sequencer.
interface labft_seq_if #(
  parameter int unsigned tileBits = 8
);
  logic                start;
  logic [tileBits-1:0] num_tiles;
  logic                abort;
  logic [3:0]          error;
  logic                interrupt;
  logic                loadingWeights;
  logic                validInputs;
  logic                validOutputs;
  logic                busy;
  logic [tileBits-1:0] tile_idx;
  logic                tile_done;
  logic                tile_retry;
  logic                done;
  logic                fault;
  logic [3:0]          err_syndrome;

  modport master (
    output start, num_tiles, abort, error,
    input  interrupt, loadingWeights, validInputs, validOutputs, busy, tile_idx,
    input  tile_done, tile_retry, done, fault, err_syndrome
  );

  modport slave (
    input  start, num_tiles, abort, error,
    output interrupt, loadingWeights, validInputs, validOutputs, busy, tile_idx,
    output tile_done, tile_retry, done, fault, err_syndrome
  );
endinterface

// File: rtl/labft_sequencer.sv
// Tile-level sequencer for the LABFT checker: clear/load/stream/drain/output/check per tile,
// then pass, retry or fault. Tile retries exist only when LABFT_SEQ_RETRY_EN is defined.
module labft_sequencer #(
  parameter int unsigned arraySize = 4,
  parameter int unsigned PIPE_LAT  = 7,
  parameter int unsigned CHECK_LAT = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned tileBits  = 8
) (
  input logic        clk,
  input logic        rst,
  labft_seq_if.slave bus
);
  localparam int unsigned MaxAP  = (arraySize > PIPE_LAT) ? arraySize : PIPE_LAT;
  localparam int unsigned MaxLat = (MaxAP > CHECK_LAT) ? MaxAP : CHECK_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;
  localparam logic [CntW-1:0] ArrLast  = CntW'(arraySize - 1);
  localparam logic [CntW-1:0] PipeLast = CntW'(PIPE_LAT - 1);
  localparam logic [CntW-1:0] ChkLast  = CntW'(CHECK_LAT - 1);

  typedef enum logic [3:0] {
    StIdle, StClear, StLoad, StStream, StDrain, StOutput, StCheck, StEval, StAbort
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic [tileBits-1:0] num_q, tile_idx_q;
  logic [3:0]          err_acc_q, syn_q;
  logic                fault_q, zero_done_q;
  logic                accept, pass, last_tile, can_retry, finish, eval_go;
  logic                intr, ld_w, vld_in, vld_out, busy, t_done, t_retry, done;

  assign accept    = (state_q == StIdle) && bus.start && !bus.abort;
  assign pass      = (err_acc_q == 4'b0);
  assign last_tile = (tile_idx_q == num_q - 1'b1);
  assign finish    = pass ? last_tile : !can_retry;
  // An abort landing on EVAL suppresses the tile verdict entirely.
  assign eval_go   = (state_q == StEval) && !bus.abort;

`ifdef LABFT_SEQ_RETRY_EN
  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RetryW-1:0] retry_q;

  assign can_retry = (retry_q < RetryW'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= '0;
    end else if (accept) begin
      retry_q <= '0;
    end else if (eval_go) begin
      if (pass)           retry_q <= '0;
      else if (can_retry) retry_q <= retry_q + 1'b1;
    end
  end
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
  assign can_retry        = 1'b0;
`endif

  // State register; the phase counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || state_q == StIdle) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept && bus.num_tiles != '0) state_d = StClear;
      StClear:  state_d = StLoad;
      StLoad:   if (cnt_q == ArrLast)  state_d = StStream;
      StStream: if (cnt_q == ArrLast)  state_d = StDrain;
      StDrain:  if (cnt_q == PipeLast) state_d = StOutput;
      StOutput: if (cnt_q == ArrLast)  state_d = StCheck;
      StCheck:  if (cnt_q == ChkLast)  state_d = StEval;
      StEval:   state_d = finish ? StIdle : StClear;
      StAbort:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (bus.abort && state_q != StIdle && state_q != StAbort) state_d = StAbort;
  end

  always_comb begin
    intr    = 1'b0;
    ld_w    = 1'b0;
    vld_in  = 1'b0;
    vld_out = 1'b0;
    unique case (state_q)
      StClear, StAbort: intr    = 1'b1;
      StLoad:           ld_w    = 1'b1;
      StStream:         vld_in  = 1'b1;
      StOutput:         vld_out = 1'b1;
      default:          ;
    endcase
    busy    = (state_q != StIdle);
    t_done  = eval_go && pass;
    t_retry = eval_go && !pass && can_retry;
    done    = zero_done_q || (eval_go && finish);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q       <= '0;
      tile_idx_q  <= '0;
      err_acc_q   <= '0;
      syn_q       <= '0;
      fault_q     <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= accept && (bus.num_tiles == '0);
      if (accept) begin
        num_q      <= bus.num_tiles;
        tile_idx_q <= '0;
        syn_q      <= '0;
        fault_q    <= 1'b0;
      end
      if (state_q == StClear) begin
        err_acc_q <= '0;
      end else if (state_q == StOutput || state_q == StCheck) begin
        err_acc_q <= err_acc_q | bus.error;
      end
      if (eval_go) begin
        if (pass) begin
          tile_idx_q <= tile_idx_q + 1'b1;
        end else begin
          syn_q <= err_acc_q;
          if (!can_retry) fault_q <= 1'b1;
        end
      end
    end
  end

  assign bus.interrupt      = intr;
  assign bus.loadingWeights = ld_w;
  assign bus.validInputs    = vld_in;
  assign bus.validOutputs   = vld_out;
  assign bus.busy           = busy;
  assign bus.tile_idx       = tile_idx_q;
  assign bus.tile_done      = t_done;
  assign bus.tile_retry     = t_retry;
  assign bus.done           = done;
  assign bus.fault          = fault_q;
  assign bus.err_syndrome   = syn_q;
endmodule

// File: tb/tb_labft_sequencer.sv
// Randomised scoreboard bench for labft_sequencer: a job-level model plans strobes, pulses and
// status per cycle; a negedge monitor compares the DUT against those plans.
module tb_labft_sequencer;
  localparam int MaxRetry = 2;
  localparam int RunLen   = 25;

  typedef struct {
    int         cyc;
    logic [2:0] kind;  // {tile_done, tile_retry, done}
    logic [7:0] idx;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       fault;
    logic [3:0] syn;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  labft_seq_if #(.tileBits(8)) bus ();

  labft_sequencer #(
    .arraySize(4),
    .PIPE_LAT (7),
    .CHECK_LAT(4),
    .MAX_RETRY(MaxRetry),
    .tileBits (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         mode = 0;  // 0: unchecked, 1: scoreboard, 2: everything must be zero
  ev_t        ev_q[$];
  st_t        st_q[$];
  logic [3:0] strobe_plan[int];
  bit         busy_plan[int];
  logic [3:0] err_plan[int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] err_at(input int k);
    return err_plan.exists(k) ? err_plan[k] : 4'h0;
  endfunction

  function automatic void add_err(input int k, input logic [3:0] v);
    err_plan[k] = err_at(k) | v;
  endfunction

  // Monitor
  logic [3:0]  m_es, m_gs;
  logic [2:0]  m_p;
  logic [20:0] m_all;
  ev_t         m_e;
  st_t         m_s;

  always @(negedge clk) begin
    m_all = {bus.interrupt, bus.loadingWeights, bus.validInputs, bus.validOutputs, bus.busy,
             bus.tile_done, bus.tile_retry, bus.done, bus.fault, bus.err_syndrome, bus.tile_idx};
    if (mode == 2) begin
      checks++;
      if (m_all !== 21'h0) begin
        errors++;
        $display("FAIL reset_zero cyc=%0d got=%h want=0", cyc, m_all);
      end
    end else if (mode == 1) begin
      m_es = strobe_plan.exists(cyc) ? strobe_plan[cyc] : 4'h0;
      m_gs = {bus.interrupt, bus.loadingWeights, bus.validInputs, bus.validOutputs};
      checks++;
      if (m_gs !== m_es) begin
        errors++;
        $display("FAIL strobes cyc=%0d got=%b want=%b", cyc, m_gs, m_es);
      end
      checks++;
      if (bus.busy !== busy_plan.exists(cyc)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, busy_plan.exists(cyc));
      end
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        m_e = ev_q.pop_front();
        checks++;
        errors++;
        $display("FAIL pulse_missing cyc=%0d got=none want=%b@%0d idx=%0d",
                 cyc, m_e.kind, m_e.cyc, m_e.idx);
      end
      m_p = {bus.tile_done, bus.tile_retry, bus.done};
      if (m_p != 3'b000 || (ev_q.size() > 0 && ev_q[0].cyc == cyc)) begin
        checks++;
        if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL pulse_unexpected cyc=%0d got=%b want=000", cyc, m_p);
        end else begin
          m_e = ev_q.pop_front();
          if ({m_p, bus.tile_idx} !== {m_e.kind, m_e.idx}) begin
            errors++;
            $display("FAIL pulse cyc=%0d got=%b idx=%0d want=%b idx=%0d",
                     cyc, m_p, bus.tile_idx, m_e.kind, m_e.idx);
          end
        end
      end
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
        m_s = st_q.pop_front();
        checks++;
        if (m_s.cyc < cyc || {bus.fault, bus.err_syndrome} !== {m_s.fault, m_s.syn}) begin
          errors++;
          $display("FAIL status cyc=%0d got=fault %b syn %b want=fault %b syn %b @%0d",
                   cyc, bus.fault, bus.err_syndrome, m_s.fault, m_s.syn, m_s.cyc);
        end
      end
    end
  end

  // Plans one job from the tile/retry rules, then drives it cycle by cycle.
  task automatic run_job(input int n, input bit do_abort);
    int         c, clr, tile, retry, ev, a, job_end, busy_end, off, sel;
    logic       fault_m;
    logic [3:0] syn_m, acc, v;
    bit         fin, can_retry;
    ev_t        e;
    st_t        s;
    ev_t        keep_ev[$];
    st_t        keep_st[$];
    c       = cyc;
    a       = -1;
    fault_m = 1'b0;
    syn_m   = 4'h0;
    ev      = c;
    s.cyc = c + 1; s.fault = 1'b0; s.syn = 4'h0;
    st_q.push_back(s);
    if (n == 0) begin
      e.cyc = c + 1; e.kind = 3'b001; e.idx = 8'd0;
      ev_q.push_back(e);
      s.cyc = c + 2;
      st_q.push_back(s);
      job_end  = c + 1;
      busy_end = c;
    end else begin
      clr = c + 1; tile = 0; retry = 0; fin = 1'b0;
      while (!fin) begin
        strobe_plan[clr] = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
          strobe_plan[clr + k]      = 4'b0100;
          strobe_plan[clr + 4 + k]  = 4'b0010;
          strobe_plan[clr + 15 + k] = 4'b0001;
        end
        for (int k = 0; k < RunLen; k++) busy_plan[clr + k] = 1'b1;
        acc = 4'h0;
        sel = $urandom_range(0, 9);
        if (sel < 3) begin
          repeat ($urandom_range(1, 3)) begin
            off = $urandom_range(16, 23);
            v   = 4'($urandom_range(1, 15));
            add_err(clr + off, v);
            acc = acc | v;
          end
        end else if (sel < 5) begin
          // Error outside OUTPUT/CHECK must not count.
          off = $urandom_range(0, 16);
          if (off == 16) off = 24;
          add_err(clr + off, 4'($urandom_range(1, 15)));
        end
`ifdef LABFT_SEQ_RETRY_EN
        can_retry = (retry < MaxRetry);
`else
        can_retry = 1'b0;
`endif
        ev    = clr + 24;
        e.cyc = ev;
        e.idx = 8'(tile);
        if (acc == 4'h0) begin
          fin    = (tile == n - 1);
          e.kind = fin ? 3'b101 : 3'b100;
          tile++;
          retry = 0;
        end else begin
          syn_m = acc;
          if (can_retry) begin
            e.kind = 3'b010;
            retry++;
          end else begin
            e.kind  = 3'b001;
            fault_m = 1'b1;
            fin     = 1'b1;
          end
        end
        ev_q.push_back(e);
        s.cyc = ev + 1; s.fault = fault_m; s.syn = syn_m;
        st_q.push_back(s);
        clr += RunLen;
      end
      job_end  = ev;
      busy_end = ev;
      if (do_abort) begin
        a = $urandom_range(c + 1, job_end);
        for (int k = a + 1; k <= job_end; k++) begin
          strobe_plan.delete(k);
          busy_plan.delete(k);
          err_plan.delete(k);
        end
        strobe_plan[a + 1] = 4'b1000;
        busy_plan[a + 1]   = 1'b1;
        while (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          if (e.cyc < a) keep_ev.push_back(e);
        end
        ev_q = keep_ev;
        while (st_q.size() > 0) begin
          s = st_q.pop_front();
          if (s.cyc <= a) keep_st.push_back(s);
        end
        st_q     = keep_st;
        busy_end = a + 1;
      end
    end
    bus.start     = 1'b1;
    bus.num_tiles = 8'(n);
    bus.abort     = 1'b0;
    bus.error     = err_at(c);
    while (cyc < busy_end + 1) begin
      @(posedge clk); #1;
      bus.start     = (cyc <= busy_end) && ($urandom_range(0, 7) == 0);
      bus.num_tiles = 8'($urandom);
      bus.abort     = (a >= 0) && (cyc == a);
      bus.error     = err_at(cyc);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.error = 4'h0;
  endtask

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.num_tiles = 8'h0;
    bus.abort     = 1'b0;
    bus.error     = 4'h0;
    mode = 2;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mode = 1;
    @(posedge clk); #1;

    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(0, 2)) begin
        // Idle noise: start with abort, lone abort and error are all ignored here.
        bus.start     = ($urandom_range(0, 3) == 0);
        bus.abort     = bus.start | 1'($urandom_range(0, 1));
        bus.num_tiles = 8'($urandom_range(1, 3));
        bus.error     = 4'($urandom);
        @(posedge clk); #1;
      end
      n = (j == 0) ? 1 : (j == 1) ? 3 : $urandom_range(0, 3);
      run_job(n, (n != 0) && ($urandom_range(0, 4) == 0));
    end
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of OUTPUT of a two-tile job.
    mode = 0;
    bus.start     = 1'b1;
    bus.num_tiles = 8'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    bus.error = 4'hf;
    rst  = 1'b1;
    mode = 2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    bus.error = 4'h0;
    mode = 1;
    run_job(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    mode = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=no_finish want=finish", cyc);
    $fatal(1, "time limit");
  end
endmodule
